// File: rtl/acos_pkg.sv
// Shared constants, FSM state type and operand clamp helper for the
// sequential Q16.16 inverse-cosine unit.
package acos_pkg;

    localparam int WORD_W = 32;

    localparam logic signed [WORD_W-1:0] ONE_Q16     = 32'sd65536;
    localparam logic signed [WORD_W-1:0] NEG_ONE_Q16 = -32'sd65536;
    localparam logic signed [WORD_W-1:0] PI_Q16      = 32'sd205887;
    localparam logic signed [WORD_W-1:0] HALF_PI_Q16 = 32'sd102944;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRIAL  = 3'd1,
        EVAL   = 3'd2,
        DECIDE = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Returns {clamped_flag, value} with value limited to [-1.0, 1.0].
    function automatic logic [WORD_W:0] clamp_q16(input logic signed [WORD_W-1:0] v);
        logic [WORD_W:0] res;
        if (v > ONE_Q16) begin
            res = {1'b1, ONE_Q16};
        end else if (v < NEG_ONE_Q16) begin
            res = {1'b1, NEG_ONE_Q16};
        end else begin
            res = {1'b0, v};
        end
        return res;
    endfunction

endpackage

// File: rtl/acos_fixed_seq_cos.sv
// Multicycle range-reduced Taylor cosine in Q16.16: one load cycle,
// ITER-1 term cycles, one output cycle; done pulses with c valid.
module cos_seq_q16
    import acos_pkg::*;
#(
    parameter int ITER = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] theta,
    output logic              done,
    output logic [WORD_W-1:0] c
);

    logic signed [WORD_W-1:0] w_theta;
    logic signed [WORD_W-1:0] w_r32;
    logic                     w_reduce;
    logic signed [63:0]       w_r;
    logic signed [63:0]       w_rr;
    logic signed [63:0]       w_r2;
    logic signed [63:0]       w_idx;
    logic signed [63:0]       w_mult;
    logic signed [63:0]       w_term;

    logic signed [63:0]       r_sum;
    logic signed [63:0]       r_num;
    logic signed [63:0]       r_fact;
    logic signed [63:0]       r_r2;
    logic [3:0]               r_cnt;
    logic                     r_run;
    logic                     r_sub;
    logic                     r_neg;
    logic                     r_done;
    logic [WORD_W-1:0]        r_c;

    // Angles past pi/2 are folded to pi - theta and the result negated.
    assign w_theta  = $signed(theta);
    assign w_reduce = (w_theta > HALF_PI_Q16);
    assign w_r32    = w_reduce ? (PI_Q16 - w_theta) : w_theta;
    assign w_r      = {{32{w_r32[31]}}, w_r32};
    assign w_rr     = w_r * w_r;
    assign w_r2     = w_rr >>> 16;
    assign w_idx    = {60'd0, r_cnt};
    assign w_mult   = (64'sd2 * w_idx + 64'sd1) * (64'sd2 * w_idx + 64'sd2);
    assign w_term   = r_num / r_fact;

    // Load, term accumulation and output registering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= 64'sd0;
            r_num  <= 64'sd0;
            r_fact <= 64'sd1;
            r_r2   <= 64'sd0;
            r_cnt  <= 4'd0;
            r_run  <= 1'b0;
            r_sub  <= 1'b0;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
            r_c    <= 32'd0;
        end else if (start) begin
            r_sum  <= {{32{ONE_Q16[31]}}, ONE_Q16};
            r_num  <= w_r2;
            r_r2   <= w_r2;
            r_fact <= 64'sd2;
            r_cnt  <= 4'd1;
            r_run  <= 1'b1;
            r_sub  <= 1'b1;
            r_neg  <= w_reduce;
            r_done <= 1'b0;
        end else if (r_run) begin
            if (r_cnt == 4'(ITER)) begin
                r_c    <= r_neg ? (32'd0 - r_sum[31:0]) : r_sum[31:0];
                r_done <= 1'b1;
                r_run  <= 1'b0;
            end else begin
                r_sum  <= r_sub ? (r_sum - w_term) : (r_sum + w_term);
                r_num  <= (r_num * r_r2) >>> 16;
                r_fact <= r_fact * w_mult;
                r_sub  <= ~r_sub;
                r_cnt  <= r_cnt + 4'd1;
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign done = r_done;
    assign c    = r_c;

endmodule

// File: rtl/acos_fixed_seq.sv
// Sequential acos in Q16.16: bit-serial bisection on theta in [0, pi],
// each trial angle checked with the multicycle cosine sub-unit.
module acos_fixed_seq
    import acos_pkg::*;
#(
    parameter int ITER       = 5,
    parameter int ANGLE_BITS = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] x,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] y,
    output logic              err
);

    localparam int BIT_W = (ANGLE_BITS > 1) ? $clog2(ANGLE_BITS) : 1;

    state_t                   r_state;
    state_t                   w_next;
    logic signed [WORD_W-1:0] r_x;
    logic [WORD_W-1:0]        r_theta;
    logic [WORD_W-1:0]        r_y;
    logic [BIT_W-1:0]         r_bit;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic                     r_err_cap;

    logic [WORD_W:0]          w_clamp;
    logic [WORD_W-1:0]        w_trial;
    logic [WORD_W-1:0]        w_cos;
    logic                     w_sub_start;
    logic                     w_sub_done;
    logic                     w_accept;
    logic                     w_last;

    assign w_clamp     = clamp_q16($signed(x));
    assign w_trial     = r_theta | (32'd1 << r_bit);
    assign w_sub_start = (r_state == TRIAL);
    assign w_last      = (r_bit == '0);
    // Trials beyond pi are rejected regardless of the cosine value.
    assign w_accept    = ($signed(w_trial) <= PI_Q16) && ($signed(w_cos) >= r_x);

    cos_seq_q16 #(
        .ITER (ITER)
    ) u_cos (
        .clk   (clk),
        .rst   (rst),
        .start (w_sub_start),
        .theta (w_trial),
        .done  (w_sub_done),
        .c     (w_cos)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? TRIAL : IDLE;
            TRIAL:   w_next = EVAL;
            EVAL:    w_next = w_sub_done ? DECIDE : EVAL;
            DECIDE:  w_next = w_last ? FINISH : TRIAL;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, theta accumulation and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x       <= 32'sd0;
            r_theta   <= 32'd0;
            r_y       <= 32'd0;
            r_bit     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cap <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x       <= $signed(w_clamp[WORD_W-1:0]);
                        r_err_cap <= w_clamp[WORD_W];
                        r_theta   <= 32'd0;
                        r_bit     <= BIT_W'(ANGLE_BITS - 1);
                        r_busy    <= 1'b1;
                    end
                end
                DECIDE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_theta <= w_trial;
                    end
                    if (!w_last) begin
                        r_bit <= r_bit - BIT_W'(1);
                    end
                end
                FINISH: begin
                    r_y    <= r_theta;
                    r_err  <= r_err_cap;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign y    = r_y;
    assign err  = r_err;

endmodule

// File: tb/tb_acos_fixed_seq.sv
// Directed and swept checks of acos_fixed_seq against hand limits and a
// reference model of the bisection search with the Taylor cosine.
module tb_acos_fixed_seq;

    localparam int ITER       = 5;
    localparam int ANGLE_BITS = 18;
    localparam int LAT        = ANGLE_BITS * (ITER + 3) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    acos_fixed_seq #(
        .ITER       (ITER),
        .ANGLE_BITS (ANGLE_BITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic        exp_err;
        int          y_lo;
        int          y_hi;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected in [%0d, %0d]", name, act, lo, hi);
        end
    endtask

    function automatic int cos_q16(input int th);
        longint r, r2, sum, num, fact, term;
        bit     neg;
        neg  = (th > 102944);
        r    = neg ? longint'(205887 - th) : longint'(th);
        r2   = (r * r) >>> 16;
        sum  = 65536;
        num  = r2;
        fact = 2;
        for (int i = 1; i < ITER; i++) begin
            term = num / fact;
            if ((i % 2) == 1) sum = sum - term;
            else              sum = sum + term;
            num  = (num * r2) >>> 16;
            fact = fact * (2 * i + 1) * (2 * i + 2);
        end
        return neg ? -int'(sum[31:0]) : int'(sum[31:0]);
    endfunction

    function automatic int acos_model(input int xin);
        int xc, th, t;
        xc = xin;
        if (xc > 65536)  xc = 65536;
        if (xc < -65536) xc = -65536;
        th = 0;
        for (int b = ANGLE_BITS - 1; b >= 0; b--) begin
            t = th | (1 << b);
            if (t <= 205887 && cos_q16(t) >= xc) th = t;
        end
        return th;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that raised done.
    task automatic run_op(input logic [31:0] xin, input int spur_at, input logic [31:0] spur_x,
                          output int yo, output logic eo, output int lat, output bit busy_ok);
        start   = 1'b1;
        x       = xin;
        busy_ok = 1'b1;
        lat     = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start = (lat == spur_at);
            x     = (lat == spur_at) ? spur_x : xin;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && lat < 400);
        start = 1'b0;
        yo    = $signed(y);
        eo    = err;
        if (done && busy) busy_ok = 1'b0;
    endtask

    vec_t vecs[6];
    int   sx[256];
    int   sy[256];

    initial begin
        int   yo, lat, y_one, y_half, tmp;
        logic eo;
        bit   busy_ok, quiet;

        vecs[0] = '{32'h0000_8000, 1'b0, 68565, 68693};
        vecs[1] = '{32'h0000_0000, 1'b0, 102880, 103008};
        vecs[2] = '{32'hFFFF_0000, 1'b0, 205887, 205887};
        vecs[3] = '{32'h0001_0000, 1'b0, 0, 512};
        vecs[4] = '{32'h0002_0000, 1'b1, 0, 512};
        vecs[5] = '{32'hFFFE_0000, 1'b1, 205887, 205887};

        rst   = 1'b0;
        start = 1'b0;
        x     = 32'd0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_y", y, 0);
        check("reset_err", err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        y_one  = 0;
        y_half = 0;
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].x, 0, 32'd0, yo, eo, lat, busy_ok);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_err", i), eo, vecs[i].exp_err);
            check_range($sformatf("vec%0d_y", i), yo, vecs[i].y_lo, vecs[i].y_hi);
            check($sformatf("vec%0d_model", i), yo, acos_model($signed(vecs[i].x)));
            check($sformatf("vec%0d_busy", i), busy_ok, 1);
            if (i == 0) y_half = yo;
            if (i == 3) y_one = yo;
            if (i == 4) check("clamp_hi_equals_one", yo, y_one);
        end

        repeat (3) @(posedge clk);
        #1;
        check("y_held", $signed(y), yo);
        check("done_single_pulse", done, 0);

        // Spurious start while busy must be ignored.
        run_op(32'h0000_8000, 10, 32'h0000_0000, yo, eo, lat, busy_ok);
        check("spur_latency", lat, LAT);
        check("spur_y", yo, y_half);
        check("spur_busy", busy_ok, 1);
        quiet = 1'b1;
        repeat (160) begin
            @(posedge clk);
            #1;
            if (done || busy) quiet = 1'b0;
        end
        check("spur_not_queued", quiet, 1);

        // Reset in the middle of an operation.
        start = 1'b1;
        x     = 32'h0000_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_y", y, 0);
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        quiet = 1'b1;
        repeat (160) begin
            @(posedge clk);
            #1;
            if (done || busy) quiet = 1'b0;
        end
        check("midrst_no_done", quiet, 1);
        run_op(32'h0000_8000, 0, 32'd0, yo, eo, lat, busy_ok);
        check("after_rst_latency", lat, LAT);
        check("after_rst_y", yo, y_half);

        // Back-to-back random sweep against the reference model.
        for (int i = 0; i < 256; i++) begin
            sx[i] = int'($urandom_range(131072)) - 65536;
            run_op(sx[i], 0, 32'd0, yo, eo, lat, busy_ok);
            sy[i] = yo;
            check($sformatf("sweep%0d_model x=%0d", i, sx[i]), yo, acos_model(sx[i]));
            check($sformatf("sweep%0d_latency", i), lat, LAT);
            check($sformatf("sweep%0d_err", i), eo, 0);
        end
        for (int i = 0; i < 255; i++) begin
            for (int j = 0; j < 255 - i; j++) begin
                if (sx[j] > sx[j+1]) begin
                    tmp = sx[j]; sx[j] = sx[j+1]; sx[j+1] = tmp;
                    tmp = sy[j]; sy[j] = sy[j+1]; sy[j+1] = tmp;
                end
            end
        end
        for (int i = 0; i < 255; i++) begin
            n_checks++;
            if (sy[i+1] > sy[i]) begin
                n_errors++;
                $display("FAIL monotonic: y(x=%0d)=%0d rises above y(x=%0d)=%0d",
                         sx[i+1], sy[i+1], sx[i], sy[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/acos_fixed_seq.md
Name: acos_fixed_seq

Overview:
- Sequential inverse cosine. Takes x in Q16.16 and returns theta = acos(x) in Q16.16 radians, range [0, pi].
- Uses successive approximation (bit-serial bisection) on theta, exploiting that cos is monotonically decreasing on [0, pi].
- Each trial angle is checked with a multicycle Taylor-series cosine sub-unit.
- Sits beside the combinational cos_fixed datapath; gives the trig library its inverse direction without a large LUT.

Parameters:
- ITER, 5, number of Taylor terms in the cosine sub-unit (1 + ITER-1 correction terms); legal range 2..8.
- ANGLE_BITS, 18, number of result bits resolved; PI_Q16 = 205887 < 2^18.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- x  in  32  signed Q16.16 operand; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; y and err are valid in that cycle and held until the next accepted start.
- y  out  32  signed Q16.16 acos result, always in [0, PI_Q16].
- err  out  1  input was outside [-ONE_Q16, ONE_Q16] and has been clamped.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, y=0, err=0; theta accumulator=0; sub-unit aborted, its done=0. A reset mid-operation discards the operation and produces no done.
- Operand capture on accepted start:
  - x > 65536 is clamped to 65536 with err=1.
  - x < -65536 is clamped to -65536 with err=1.
  - Otherwise the operand is captured unchanged with err=0.
- start while busy is ignored: no queuing, operand unchanged.
- FSM: IDLE -> TRIAL -> EVAL -> DECIDE -> (TRIAL for the next bit | FINISH) -> IDLE.
  - TRIAL (1 cycle): trial = theta | (1 << b), with b running from ANGLE_BITS-1 down to 0. Pulse sub-unit start with the trial angle.
  - EVAL: wait for the sub-unit done, which comes exactly ITER+1 cycles after its start.
  - DECIDE (1 cycle): accept the trial (theta = trial) iff trial <= PI_Q16 AND cos(trial) >= captured x, as a signed compare. If trial > PI_Q16 the cos result is ignored and the trial is rejected. The sub-unit still runs, so latency stays fixed.
  - FINISH (1 cycle): y = theta, done=1, busy=0.
- Fixed latency: done is asserted exactly ANGLE_BITS*(ITER+3)+1 cycles after the start-sampling edge (145 cycles at defaults). Back-to-back: a start is accepted in the cycle after done.
- Result definition: y is the largest theta in [0, PI_Q16] with cos_q16(theta) >= x, where cos_q16 is the sub-unit function below.
- Sub-unit cos function (bit-exact; the bench model must match):
  - Range reduction: if theta > HALF_PI_Q16, r = PI_Q16 - theta and the result is negated; else r = theta.
  - Compute r2 = (r*r) >>> 16, with 64-bit signed intermediates.
  - Initialise sum = ONE_Q16, num = r2, fact = 2, sign = subtract.
  - Each term cycle (ITER-1 cycles):
    - term = num / fact, truncating toward zero;
    - sum = sum -/+ term according to sign;
    - num = (num*r2) >>> 16;
    - fact *= (2i+1)(2i+2);
    - sign toggles.
  - The final result is sum[31:0], negated if range reduction applied.
  - Timing: 1 load cycle + ITER-1 term cycles + 1 output cycle.
- Arithmetic: all products in 64-bit signed. Factorial fits in 64 bits for ITER <= 8.

Decomposition:
- Package acos_pkg:
  - Constants: ONE_Q16 = 65536, PI_Q16 = 205887, HALF_PI_Q16 = 102944.
  - FSM state enum: IDLE, TRIAL, EVAL, DECIDE, FINISH.
  - Q16.16 word width constant: 32.
- One sub-module, cos_seq_q16. Ports: clk, rst, start, theta[31:0], done, c[31:0]. Parameter ITER. Implements the range-reduced multicycle Taylor evaluation above.

Test Plan:
- x=0x0000_8000 (0.5) -> done exactly 145 cycles after start; y within 68629 ±64 (pi/3); err=0.
- x=0x0000_0000 -> y within 102944 ±64; x=0xFFFF_0000 (-1.0) -> y == 205887 exactly; err=0.
- x=0x0001_0000 (1.0) -> y <= 0x200 (Taylor flat zone near 0); x=0x0002_0000 -> err=1, y identical to the x=1.0 result.
- start pulsed again at cycle 10 of a busy operation with a different x -> ignored; result matches the first x; busy stays high until the single done.
- Assert rst at cycle 50 of an operation -> busy=0, done=0, y=0 immediately; no done pulse follows; a new start after release completes in 145 cycles.
- Sweep 256 random x in [-1,1], back-to-back starts -> y bit-exact vs. the reference model of the search plus cos_q16; y monotonically non-increasing over a sorted sweep.
